// File: rtl/my_tx_if.sv
// Byte-in / serial-out handshake bundle for the my_tx UART transmitter.
// The master side offers bytes; the slave side (the transmitter) drives the line.
interface my_tx_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       done;

  modport master (output valid, output data, input ready, input tx, input done);
  modport slave  (input valid, input data, output ready, output tx, output done);
endinterface

// File: rtl/my_tx.sv
// UART transmitter: accepts one byte per valid/ready handshake and serialises it
// as start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module my_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic     clk,
  input logic     rst_n,
  my_tx_if.slave  bus
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic            LAST_STP = 1'(STOP_BITS - 1);
  localparam logic            ODD_PAR  = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bus.ready = ready_q;
  assign bus.tx    = tx_q;
  assign bus.done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Line level, ready and done are all computed from the next state so that
  // each is a clean register output aligned with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    bit_end = (cnt_q == LAST_CNT);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.valid && ready_q) begin
          shift_d = bus.data;
          par_d   = (^bus.data) ^ ODD_PAR;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
  end

endmodule

// File: doc/my_tx.md
MY_TX -- requirements
Module: my_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per serial bit (legal range 2..255).
REQ-002 The block SHALL have parameter PARITY, default 0, with 0 = none, 1 = even, 2 = odd.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, with legal values 1 or 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port valid, input, 1 bit: byte offered on data.
REQ-007 The block SHALL have port data, input, 8 bits: byte to transmit.
REQ-008 The block SHALL have port ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-011 The block SHALL implement the state machine IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
REQ-012 The PARITY state SHALL be skipped when PARITY=0.
REQ-013 In IDLE, ready SHALL be 1 and tx SHALL be 1; in every other state, ready SHALL be 0.
REQ-014 A handshake SHALL occur on the rising edge where valid=1 and ready=1: data is latched into an internal shift register, the state goes to START, and the bit counter clears.
REQ-015 data and valid SHALL be ignored while ready=0; a change to data mid-frame SHALL NOT alter the frame.
REQ-016 tx SHALL be driven from a register and be glitch-free.
REQ-017 tx SHALL go low in the first cycle after the handshake edge.
REQ-018 Every bit SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-019 Data bits SHALL be sent LSB first: bit 0 through bit 7, tracked by a 3-bit index.
REQ-020 The parity bit SHALL be XOR of the 8 latched bits for even parity, and its inverse for odd parity.
REQ-021 The stop phase SHALL hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-022 The frame length SHALL be (9 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first low cycle of tx.
REQ-023 done SHALL pulse high for exactly one cycle: the first IDLE cycle after the stop phase ends, in which ready is also 1.
REQ-024 Back-to-back: a byte accepted in that same done cycle SHALL start its start bit on the next cycle, giving exactly one idle-high cycle between frames.
REQ-025 The clock counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-026 The clock counter SHALL never exceed CLKS_PER_BIT-1.
REQ-027 valid held high continuously SHALL send one frame per handshake.
REQ-028 valid held high continuously SHALL NOT cause duplicate frames within a single IDLE cycle.

Reset
REQ-029 While rst_n=0, and immediately on assertion, the block SHALL set tx=1, ready=0, done=0, state=IDLE, and clear the counters and shift register.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done pulse; the line returns high asynchronously.
REQ-031 After rst_n deasserts, ready SHALL go to 1 on the first rising clk edge.

Verification
REQ-032 Scenario, basic frame: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, send 0xA5 -> tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; done pulses at cycle 41 after the handshake; 40-cycle frame.
REQ-033 Scenario, parity: PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; PARITY=1 with 0x00 -> parity bit 0; frame is 44 cycles at CLKS_PER_BIT=4.
REQ-034 Scenario, back-to-back: valid held high with data 0x00 then 0xFF -> two frames separated by exactly one idle-high cycle; two done pulses.
REQ-035 Scenario, data change mid-frame: data changes from 0x3C to 0xC3 at bit 3 -> received line bits still decode to 0x3C; valid pulses while busy produce no extra frame.
REQ-036 Scenario, reset mid-frame: rst_n pulsed low during data bit 4 -> tx=1 immediately, no done pulse, ready=1 on the first edge after release, and the next frame is correct.
REQ-037 Scenario, loopback: STOP_BITS=2 with the team receiver on tx sending 0x55 -> receiver outputs 0x55 with ready, and tx stays high for 8 cycles of stop.
